pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  - Owns the program counter for the 8-bit single-cycle CPU and sequences its update each cycle.
//  - Forms branch/jump targets from the instruction's signed word offset (offset << 2 added to PC+4).
//  - Freezes the PC while memory asserts BUSYWAIT, and holds any branch decision made during the stall.
//  - Counts committed redirects for performance monitoring.
//  - Sits between the control unit/ALU (decision inputs) and the instruction memory (PC output).
// PARAMETERS
//  - PC_WIDTH     32   width of PC and of target arithmetic
//  - OFFSET_BITS  8    width of the signed word-offset field from the instruction
//  - RESET_PC     0    PC value loaded on reset
//  - CNT_WIDTH    16   width of the saturating redirect counter
// PORTS
//  - CLK           in   1            rising-edge clock
//  - RESET         in   1            asynchronous, active-low reset
//  - BUSYWAIT      in   1            memory stall; 1 = PC must not advance
//  - JUMP          in   1            unconditional jump for current instruction
//  - BRANCH_EQ     in   1            beq: taken when ZERO=1
//  - BRANCH_NE     in   1            bne: taken when ZERO=0
//  - ZERO          in   1            ALU zero flag for current instruction
//  - OFFSET        in   OFFSET_BITS  signed word offset (two's complement)
//  - PC            out  PC_WIDTH     current instruction address (registered)
//  - STALLED       out  1            registered; 1 while in HOLD state
//  - REDIRECT      out  1            registered 1-cycle pulse after PC loaded with a target
//  - BR_TAKEN_CNT  out  CNT_WIDTH    committed-redirect count, saturating
// BEHAVIOUR
//  - Reset (RESET=0, async): PC=RESET_PC, state=RUN, pend_valid=0, pend_target=0, STALLED=0, REDIRECT=0, BR_TAKEN_CNT=0.
//  - Reset mid-stall: pending decision is discarded and the block restarts in RUN.
//  - take (combinational) = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO).
//    JUMP is independent of ZERO.
//    BRANCH_EQ=BRANCH_NE=1 yields take=1 for either ZERO value.
//  - pc_plus4 = PC + 4, modulo 2^PC_WIDTH.
//  - target = pc_plus4 + (sign_extend(OFFSET) << 2), modulo 2^PC_WIDTH; no overflow detection.
//  - State RUN, BUSYWAIT=0 at posedge:
//    - PC <= take ? target : pc_plus4.
//    - REDIRECT <= take.
//    - Counter increments if take. Stay in RUN.
//  - State RUN, BUSYWAIT=1 at posedge:
//    - PC holds.
//    - pend_valid <= take; pend_target <= target.
//    - STALLED <= 1; REDIRECT <= 0. Go to HOLD.
//  - State HOLD, BUSYWAIT=1: PC, pending state and counter hold.
//    JUMP/BRANCH_*/ZERO/OFFSET are ignored (decision frozen at stall entry).
//  - State HOLD, BUSYWAIT=0 at posedge:
//    - PC <= pend_valid ? pend_target : pc_plus4.
//    - REDIRECT <= pend_valid; counter increments if pend_valid.
//    - pend_valid <= 0; STALLED <= 0. Go to RUN.
//  - Latency: a decision commits at the first posedge with BUSYWAIT=0; PC never advances during a stall.
//  - Counter saturates at all-ones; it never wraps.
//  - REDIRECT is high for exactly one cycle per committed redirect.
// TESTING
//  - Release reset, BUSYWAIT=0, no control for 3 cycles -> PC = 0, 4, 8, 12; REDIRECT=0; counter=0.
//  - PC=0x10, BRANCH_EQ=1, ZERO=1, OFFSET=8'hFE (-2)
//    -> next PC = 0x14 - 8 = 0x0C; REDIRECT=1 for one cycle; counter=1.
//  - PC=0x10, BRANCH_NE=1, ZERO=1 -> PC=0x14, REDIRECT=0.
//  - PC=0x20, JUMP=1, OFFSET=8'h03, BUSYWAIT=1 for 3 cycles (inputs changed to 0 during stall):
//    - PC stays 0x20 and STALLED=1 during the stall.
//    - First cycle with BUSYWAIT=0 -> PC=0x30; REDIRECT=1.
//  - PC=0xFFFFFFFC with no branch -> PC wraps to 0x0.
//    Counter preset near all-ones with 3 taken jumps -> counter holds at all-ones.
//  - Assert RESET=0 mid-HOLD with pend_valid=1 -> PC=RESET_PC and STALLED=0 immediately.
//    After release, first cycle -> PC=4 (pending jump not applied).

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer for the 8-bit single-cycle CPU: PC+4 / branch / jump update,
// memory-stall freeze with a held branch decision, and a saturating redirect counter.
module pc_sequencer #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned OFFSET_BITS = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   BUSYWAIT,
    input  logic                   JUMP,
    input  logic                   BRANCH_EQ,
    input  logic                   BRANCH_NE,
    input  logic                   ZERO,
    input  logic [OFFSET_BITS-1:0] OFFSET,
    output logic [PC_WIDTH-1:0]    PC,
    output logic                   STALLED,
    output logic                   REDIRECT,
    output logic [CNT_WIDTH-1:0]   BR_TAKEN_CNT
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_nxt;
    logic                  r_pend_valid;
    logic                  w_pend_valid_nxt;
    logic [PC_WIDTH-1:0]   r_pend_target;
    logic [PC_WIDTH-1:0]   w_pend_target_nxt;
    logic                  r_stalled;
    logic                  w_stalled_nxt;
    logic                  r_redirect;
    logic                  w_redirect_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic                  w_commit;

    logic                  w_take;
    logic [PC_WIDTH-1:0]   w_pc_plus4;
    logic [PC_WIDTH-1:0]   w_offset_ext;
    logic [PC_WIDTH-1:0]   w_target;

    // Decision and target arithmetic for the current instruction
    assign w_take       = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
    assign w_pc_plus4   = r_pc + PC_WIDTH'(4);
    assign w_offset_ext = {{(PC_WIDTH-OFFSET_BITS){OFFSET[OFFSET_BITS-1]}}, OFFSET};
    assign w_target     = w_pc_plus4 + (w_offset_ext << 2);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
            r_stalled     <= 1'b0;
            r_redirect    <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_stalled     <= w_stalled_nxt;
            r_redirect    <= w_redirect_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        w_stalled_nxt     = r_stalled;
        w_redirect_nxt    = 1'b0;
        w_commit          = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (BUSYWAIT) begin
                    // Freeze the decision at stall entry; it commits when memory releases
                    w_pend_valid_nxt  = w_take;
                    w_pend_target_nxt = w_target;
                    w_stalled_nxt     = 1'b1;
                    w_state_nxt       = ST_HOLD;
                end else begin
                    w_pc_nxt       = w_take ? w_target : w_pc_plus4;
                    w_redirect_nxt = w_take;
                    w_commit       = w_take;
                end
            end
            ST_HOLD: begin
                if (!BUSYWAIT) begin
                    w_pc_nxt         = r_pend_valid ? r_pend_target : w_pc_plus4;
                    w_redirect_nxt   = r_pend_valid;
                    w_commit         = r_pend_valid;
                    w_pend_valid_nxt = 1'b0;
                    w_stalled_nxt    = 1'b0;
                    w_state_nxt      = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        w_cnt_nxt = (w_commit && (r_cnt != '1)) ? r_cnt + CNT_WIDTH'(1) : r_cnt;
    end

    assign PC           = r_pc;
    assign STALLED      = r_stalled;
    assign REDIRECT     = r_redirect;
    assign BR_TAKEN_CNT = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance with a 2-bit counter exercises saturation.
module tb_pc_sequencer;

    logic        CLK;
    logic        RESET;
    logic        BUSYWAIT;
    logic        JUMP;
    logic        BRANCH_EQ;
    logic        BRANCH_NE;
    logic        ZERO;
    logic [7:0]  OFFSET;
    logic [31:0] pc;
    logic        stalled;
    logic        redirect;
    logic [15:0] cnt;
    logic [31:0] sat_pc;
    logic        sat_stalled;
    logic        sat_redirect;
    logic [1:0]  sat_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer u_dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BUSYWAIT     (BUSYWAIT),
        .JUMP         (JUMP),
        .BRANCH_EQ    (BRANCH_EQ),
        .BRANCH_NE    (BRANCH_NE),
        .ZERO         (ZERO),
        .OFFSET       (OFFSET),
        .PC           (pc),
        .STALLED      (stalled),
        .REDIRECT     (redirect),
        .BR_TAKEN_CNT (cnt)
    );

    pc_sequencer #(.CNT_WIDTH(2)) u_sat (
        .CLK          (CLK),
        .RESET        (RESET),
        .BUSYWAIT     (BUSYWAIT),
        .JUMP         (JUMP),
        .BRANCH_EQ    (BRANCH_EQ),
        .BRANCH_NE    (BRANCH_NE),
        .ZERO         (ZERO),
        .OFFSET       (OFFSET),
        .PC           (sat_pc),
        .STALLED      (sat_stalled),
        .REDIRECT     (sat_redirect),
        .BR_TAKEN_CNT (sat_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    endtask

    task automatic ctl(input logic j, input logic beq, input logic bne, input logic z,
                       input logic [7:0] off, input logic bw);
        JUMP = j; BRANCH_EQ = beq; BRANCH_NE = bne; ZERO = z; OFFSET = off; BUSYWAIT = bw;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_run(input string tag, input logic [31:0] e_pc, input logic e_redir,
                           input logic e_stall, input logic [15:0] e_cnt);
        chk({tag, ".pc"},       pc,              e_pc);
        chk({tag, ".redirect"}, 32'(redirect),   32'(e_redir));
        chk({tag, ".stalled"},  32'(stalled),    32'(e_stall));
        chk({tag, ".cnt"},      32'(cnt),        32'(e_cnt));
    endtask

    initial begin
        RESET = 1'b0;
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #13;
        chk_run("reset", 32'h0, 1'b0, 1'b0, 16'd0);
        chk("reset.sat_cnt", 32'(sat_cnt), 32'd0);

        RESET = 1'b1;
        #1;
        chk("release.pc", pc, 32'h0);
        step(); chk_run("seq1", 32'h4, 1'b0, 1'b0, 16'd0);
        step(); chk_run("seq2", 32'h8, 1'b0, 1'b0, 16'd0);
        step(); chk_run("seq3", 32'hC, 1'b0, 1'b0, 16'd0);
        step(); chk("seq4.pc", pc, 32'h10);

        // beq taken, negative offset: 0x14 - 8
        ctl(1'b0, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0);
        step(); chk_run("beq_taken", 32'hC, 1'b1, 1'b0, 16'd1);
        chk("beq_taken.sat_cnt", 32'(sat_cnt), 32'd1);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(); chk_run("after_beq", 32'h10, 1'b0, 1'b0, 16'd1);

        ctl(1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 1'b0);
        step(); chk_run("bne_not", 32'h14, 1'b0, 1'b0, 16'd1);
        ctl(1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 1'b0);
        step(); chk_run("beq_not", 32'h18, 1'b0, 1'b0, 16'd1);
        // both branch flags with ZERO=0: taken, 0x1C + 4
        ctl(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0);
        step(); chk_run("beq_bne", 32'h20, 1'b1, 1'b0, 16'd2);

        // jump decided at stall entry, inputs change during the stall
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 1'b1);
        step(); chk_run("stall1", 32'h20, 1'b0, 1'b1, 16'd2);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(); chk_run("stall2", 32'h20, 1'b0, 1'b1, 16'd2);
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b1);
        step(); chk_run("stall3", 32'h20, 1'b0, 1'b1, 16'd2);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(); chk_run("stall_commit", 32'h30, 1'b1, 1'b0, 16'd3);
        chk("stall_commit.sat_cnt", 32'(sat_cnt), 32'd3);
        step(); chk_run("pulse_end", 32'h34, 1'b0, 1'b0, 16'd3);

        // stall with no decision
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(); chk_run("stall_nt", 32'h34, 1'b0, 1'b1, 16'd3);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(); chk_run("stall_nt_rel", 32'h38, 1'b0, 1'b0, 16'd3);

        // jump ignores ZERO; 0x3C - 0x40 = 0xFFFFFFFC, then wrap
        ctl(1'b1, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0);
        step(); chk_run("jump_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 16'd4);
        chk("jump_top.sat_cnt", 32'(sat_cnt), 32'd3);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(); chk_run("wrap", 32'h0, 1'b0, 1'b0, 16'd4);

        // three more taken jumps: 2-bit counter stays at all-ones
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(); chk("sat_j1", 32'(sat_cnt), 32'd3);
        step(); chk("sat_j2", 32'(sat_cnt), 32'd3);
        step(); chk_run("sat_j3", 32'hC, 1'b1, 1'b0, 16'd7);
        chk("sat_j3.sat_cnt", 32'(sat_cnt), 32'd3);
        chk("sat_j3.sat_pc", sat_pc, 32'hC);
        chk("sat_j3.sat_redirect", 32'(sat_redirect), 32'd1);

        // reset in the middle of a stall holding a pending jump
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1);
        step(); chk_run("pre_rst_hold", 32'hC, 1'b0, 1'b1, 16'd7);
        chk("pre_rst_hold.sat_stalled", 32'(sat_stalled), 32'd1);
        #2 RESET = 1'b0;
        #1;
        chk_run("rst_mid_hold", 32'h0, 1'b0, 1'b0, 16'd0);
        chk("rst_mid_hold.sat_stalled", 32'(sat_stalled), 32'd0);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        chk("rst_held.pc", pc, 32'h0);
        RESET = 1'b1;
        step(); chk_run("after_rst", 32'h4, 1'b0, 1'b0, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
